next_piece_queue: RTL and testbench

Parametrised successor to the single-register next-block selector. It holds the current piece plus DEPTH preview pieces in a shift queue, filled from a free-running random source. Out-of-range random values are rejected. An optional 7-bag mode suppresses repeats until every shape has been dealt once. It sits between the LFSR random source and the game control FSM, which pulses `next` to consume the current piece.

---
 rtl/next_piece_queue_if.sv | 33 +++
 rtl/next_piece_queue.sv | 82 ++++++++
 tb/tb_next_piece_queue.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/next_piece_queue_if.sv
// Handshake bundle between the random source / game FSM (master) and the piece queue (slave).
// next is a single-cycle consume pulse; it only takes effect while valid is high.
interface next_piece_queue_if #(
  parameter int SHAPE_W = 3,
  parameter int DEPTH   = 3
);
  localparam int CNT_W = $clog2(DEPTH + 2);

  logic                       next;
  logic [SHAPE_W-1:0]         random;
  logic [SHAPE_W-1:0]         shape;
  logic [DEPTH*SHAPE_W-1:0]   preview;
  logic                       valid;
  logic [CNT_W-1:0]           count;

  modport master (
    output next,
    output random,
    input  shape,
    input  preview,
    input  valid,
    input  count
  );

  modport slave (
    input  next,
    input  random,
    output shape,
    output preview,
    output valid,
    output count
  );
endinterface

// File: rtl/next_piece_queue.sv
// Current piece plus DEPTH preview pieces in a shift queue, fed from a free-running
// random source with range rejection and an optional 7-bag no-repeat filter.
module next_piece_queue #(
  parameter int SHAPE_W    = 3,
  parameter int NUM_SHAPES = 7,
  parameter int DEPTH      = 3,
  parameter int BAG_MODE   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  next_piece_queue_if.slave   bus
);
  localparam int ENTRIES = DEPTH + 1;
  localparam int CNT_W   = $clog2(DEPTH + 2);
  localparam int BAG_W   = 2 ** SHAPE_W;

  localparam logic [CNT_W-1:0]   ENTRIES_C = CNT_W'(ENTRIES);
  localparam logic [SHAPE_W:0]   NUM_C     = (SHAPE_W + 1)'(NUM_SHAPES);
  localparam logic [BAG_W-1:0]   FULL_BAG  = BAG_W'((64'd1 << NUM_SHAPES) - 64'd1);

  logic [SHAPE_W-1:0] entries_q [ENTRIES];
  logic [SHAPE_W-1:0] entries_d [ENTRIES];
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BAG_W-1:0]   bag_q, bag_d;

  logic               pop;
  logic               in_range;
  logic               bag_ok;
  logic               accept;
  logic [CNT_W-1:0]   count_after_pop;
  logic [BAG_W-1:0]   bag_set;

  always_comb begin
    pop             = bus.next && (count_q == ENTRIES_C);
    count_after_pop = count_q - CNT_W'(pop);
    in_range        = {1'b0, bus.random} < NUM_C;
    bag_ok          = (BAG_MODE == 0) || !bag_q[bus.random];
    // Room is judged after this cycle's pop so a full queue can pop and push together.
    accept          = in_range && bag_ok && (count_after_pop < ENTRIES_C);
    count_d         = count_after_pop + CNT_W'(accept);

    for (int i = 0; i < ENTRIES - 1; i++) begin
      entries_d[i] = pop ? entries_q[i+1] : entries_q[i];
    end
    entries_d[ENTRIES-1] = pop ? '0 : entries_q[ENTRIES-1];
    if (accept) begin
      entries_d[count_after_pop] = bus.random;
    end

    bag_set = bag_q | (BAG_W'(1) << bus.random);
    bag_d   = bag_q;
    if ((BAG_MODE != 0) && accept) begin
      // A completed bag restarts empty in the same cycle.
      bag_d = (bag_set == FULL_BAG) ? '0 : bag_set;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
      count_q <= '0;
      bag_q   <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= entries_d[i];
      end
      count_q <= count_d;
      bag_q   <= bag_d;
    end
  end

  always_comb begin
    bus.shape = entries_q[0];
    for (int i = 0; i < DEPTH; i++) begin
      bus.preview[i*SHAPE_W +: SHAPE_W] = entries_q[i+1];
    end
    bus.count = count_q;
    bus.valid = (count_q == ENTRIES_C);
  end
endmodule

// File: tb/tb_next_piece_queue.sv
// Directed bench for next_piece_queue with default parameters (7 shapes, DEPTH 3, bag mode).
module tb_next_piece_queue;
  localparam int SHAPE_W = 3;
  localparam int DEPTH   = 3;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  next_piece_queue_if #(.SHAPE_W(SHAPE_W), .DEPTH(DEPTH)) bus ();

  next_piece_queue #(
    .SHAPE_W(SHAPE_W), .NUM_SHAPES(7), .DEPTH(DEPTH), .BAG_MODE(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int prev(input int i);
    return int'(bus.preview[i*SHAPE_W +: SHAPE_W]);
  endfunction

  // Drive inputs, take one rising edge, then settle before sampling.
  task automatic step(input logic nxt, input logic [SHAPE_W-1:0] rnd);
    bus.next   = nxt;
    bus.random = rnd;
    @(posedge clk);
    #1;
    bus.next   = 1'b0;
    bus.random = 3'd7;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(1'b0, 3'd7);
    rst_n = 1'b1;
  endtask

  task automatic check_state(input string tag, input int s, input int p0, input int p1,
                             input int p2, input int cnt, input int vld);
    check_eq({tag, ".shape"}, int'(bus.shape), s);
    check_eq({tag, ".p0"},    prev(0), p0);
    check_eq({tag, ".p1"},    prev(1), p1);
    check_eq({tag, ".p2"},    prev(2), p2);
    check_eq({tag, ".count"}, int'(bus.count), cnt);
    check_eq({tag, ".valid"}, int'(bus.valid), vld);
  endtask

  task automatic fill_2351();
    step(1'b0, 3'd2);
    step(1'b0, 3'd3);
    step(1'b0, 3'd5);
    step(1'b0, 3'd1);
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    bus.next   = 1'b0;
    bus.random = 3'd7;

    // Reset state
    do_reset();
    check_state("rst", 0, 0, 0, 0, 0, 0);

    // Fill with 2,3,5,1
    step(1'b0, 3'd2);
    step(1'b0, 3'd3);
    step(1'b0, 3'd5);
    check_state("fill3", 2, 3, 5, 0, 3, 0);
    step(1'b0, 3'd1);
    check_state("fill4", 2, 3, 5, 1, 4, 1);

    // Out-of-range value never accepted
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 3'd7);
      check_eq("rng7.count", int'(bus.count), 0);
      check_eq("rng7.valid", int'(bus.valid), 0);
      check_eq("rng7.shape", int'(bus.shape), 0);
    end

    // Repeats rejected within a bag
    do_reset();
    step(1'b0, 3'd4);
    step(1'b0, 3'd4);
    step(1'b0, 3'd4);
    step(1'b0, 3'd6);
    check_state("rep", 4, 6, 0, 0, 2, 0);

    // Bag completion clears the mask
    do_reset();
    step(1'b0, 3'd0);
    step(1'b0, 3'd1);
    step(1'b0, 3'd2);
    step(1'b0, 3'd3);
    check_state("bag.full", 0, 1, 2, 3, 4, 1);
    step(1'b1, 3'd4);
    check_state("bag.pp4", 1, 2, 3, 4, 4, 1);
    step(1'b1, 3'd5);
    check_state("bag.pp5", 2, 3, 4, 5, 4, 1);
    step(1'b1, 3'd0);
    check_state("bag.rej0", 3, 4, 5, 0, 3, 0);
    step(1'b0, 3'd6);
    check_state("bag.push6", 3, 4, 5, 6, 4, 1);
    step(1'b1, 3'd0);
    check_state("bag.new0", 4, 5, 6, 0, 4, 1);

    // Full queue without pop: candidate dropped, mask untouched
    step(1'b0, 3'd1);
    check_state("full.nopop", 4, 5, 6, 0, 4, 1);
    step(1'b1, 3'd1);
    check_state("full.pp1", 5, 6, 0, 1, 4, 1);

    // Simultaneous pop and push
    do_reset();
    fill_2351();
    step(1'b1, 3'd0);
    check_state("pp0", 3, 5, 1, 0, 4, 1);

    // Pop without push
    do_reset();
    fill_2351();
    step(1'b1, 3'd7);
    check_state("pop7", 3, 5, 1, 0, 3, 0);

    // next while not valid is ignored
    do_reset();
    step(1'b1, 3'd7);
    check_state("nv.empty", 0, 0, 0, 0, 0, 0);
    step(1'b0, 3'd2);
    step(1'b1, 3'd7);
    check_state("nv.one", 2, 0, 0, 0, 1, 0);
    step(1'b0, 3'd3);
    step(1'b0, 3'd5);
    step(1'b0, 3'd1);
    check_state("nv.full", 2, 3, 5, 1, 4, 1);

    // Mid-operation reset dominates next/random and clears the mask
    rst_n = 1'b0;
    step(1'b1, 3'd4);
    rst_n = 1'b1;
    check_state("midrst", 0, 0, 0, 0, 0, 0);
    fill_2351();
    check_state("refill", 2, 3, 5, 1, 4, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
